cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the 5-bit-address CPU.
- It is the command side of the program counter interface: it drives the counter's `load` and `enable` strobes. It also drives the memory, instruction-register and accumulator strobes.
- One instruction takes exactly 8 clocks. HLT freezes the sequencer until reset.
- The outputs are the counter's environmental contract: `load` and `enable` are never high in the same cycle.

Parameters:
- OP_WIDTH, 3, opcode width; fixed at 3, and elaboration fails on any other value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  OP_WIDTH  instruction-register opcode field; stable from phase IDLE through STORE.
- zero  input  1  accumulator-is-zero flag; sampled combinationally in ALU_OP.
- sel  output  1  memory address mux: 1 selects PC, 0 selects IR operand.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- load_ir  output  1  instruction register load.
- load_ac  output  1  accumulator load.
- pc_load  output  1  drives counter `load` (jump target on counter `data`).
- pc_inc  output  1  drives counter `enable`.
- data_e  output  1  accumulator-to-data-bus tristate enable.
- halt  output  1  sticky halt indicator.
- phase  output  3  current phase, for debug and assertions.

Behaviour:
- State:
  - 3-bit phase register (phase_t), advances +1 per clock; 7 wraps to 0.
  - halted flag, 1 bit.
- Reset (async, rst=1):
  - phase=INST_ADDR(0), halted=0.
  - Every output is 0 except sel=1, because sel is decoded from phase 0.
  - Outputs settle without a clock edge.
  - Reset mid-instruction abandons the instruction. The first rising edge with rst=0 moves phase to 1.
- Decode: outputs are a pure combinational function of phase, halted, opcode and zero. Each strobe is valid for exactly the cycle(s) listed below, and ALU-class means ADD, AND, XOR or LDA.
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, mem_rd.
  - 2 INST_LOAD: sel, mem_rd, load_ir.
  - 3 IDLE: sel, mem_rd, load_ir.
  - 4 OP_ADDR: pc_inc, unless opcode==HLT. If opcode==HLT: halt=1, no pc_inc, and halted sets on this edge.
  - 5 OP_FETCH: mem_rd if ALU-class.
  - 6 ALU_OP: mem_rd if ALU-class; pc_inc if SKZ and zero=1; pc_load if JMP; data_e if STO.
  - 7 STORE: mem_rd and load_ac if ALU-class; mem_wr and data_e if STO.
- Halted:
  - phase holds at 4 (OP_ADDR).
  - halt=1; all other strobes are 0.
  - Only rst clears it.
- Opcodes (cpu_pkg): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Invariants, checked every cycle:
  - !(pc_load && pc_inc).
  - !(mem_rd && mem_wr).
  - mem_wr implies data_e.
  - pc_load is at most 1 cycle per instruction.
  - pc_inc is at most 2 cycles per instruction, and 2 only for SKZ with zero=1.
  - All outputs are free of X/Z whenever rst=0.
- JMP: pc_load is a single pulse in ALU_OP. There is no increment in STORE. The next fetch uses the loaded PC.
- SKZ with zero=0: exactly one pc_inc per instruction (in OP_ADDR).
- zero is used only in phase 6. Changes to it in other phases have no effect.

Decomposition:
- cpu_pkg: opcode_t enum (8 codes above) and phase_t enum (INST_ADDR..STORE, 3 bits).
- cpu_pkg also holds the OP_WIDTH/phase width localparams and the is_alu_op() function.
- Sub-module cpu_seq_decode: the combinational phase/opcode/zero/halted to strobe decode.
- cpu_sequencer keeps the phase register and halted flag, and instantiates cpu_seq_decode.

Test Plan:
- Reset mid-cycle:
  - Stimulus: rst=1 pulse while phase=5.
  - Required: phase=0, sel=1, all other outputs 0 immediately; after release, phase steps 1,2,3 on successive clocks.
- ADD (opcode=2):
  - Required: mem_rd high in phases 1,2,3,5,6,7; load_ir in 2,3; pc_inc only in 4; load_ac only in 7; pc_load never.
- JMP (opcode=7):
  - Required: pc_load=1 only in phase 6; pc_inc=1 only in phase 4; no cycle with both.
- SKZ:
  - With zero=1 in phase 6: pc_inc pulses in phases 4 and 6 (PC advances 2).
  - With zero=0: pc_inc pulses in phase 4 only.
- STO (opcode=6):
  - Required: data_e in phases 6,7; mem_wr only in 7; mem_rd=0 in phases 5-7.
- HLT (opcode=0):
  - Required: halt=1 from phase 4, and phase stays 4 for 20 clocks with pc_inc=0.
  - Then rst=1 gives halt=0 and phase=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the 5-bit-address CPU sequencer.
//   opcode_t  - 3-bit instruction opcodes
//   phase_t   - 8-phase instruction cycle, INST_ADDR..STORE
//   is_alu_op - true for instructions that read an operand into the accumulator
package cpu_pkg;

  localparam int unsigned OP_WIDTH = 3;
  localparam int unsigned PHASE_W  = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  function automatic logic is_alu_op(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: sequencer <-> datapath signal bundle.
//   opcode, zero       - datapath to sequencer (IR opcode field, accumulator zero flag)
//   sel .. halt        - sequencer strobes to memory, IR, accumulator and PC counter
//   phase              - current phase, for debug/assertions
// master = sequencer side, slave = datapath side.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 3
);
  logic [OP_WIDTH-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                mem_rd;
  logic                mem_wr;
  logic                load_ir;
  logic                load_ac;
  logic                pc_load;
  logic                pc_inc;
  logic                data_e;
  logic                halt;
  logic [PHASE_W-1:0]  phase;

  modport master (
    input  opcode, zero,
    output sel, mem_rd, mem_wr, load_ir, load_ac, pc_load, pc_inc, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, mem_rd, mem_wr, load_ir, load_ac, pc_load, pc_inc, data_e, halt, phase
  );
endinterface

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: pure combinational strobe decode.
//   phase_i, halted_i, opcode_i, zero_i -> sel_o, mem_rd_o, mem_wr_o, load_ir_o,
//   load_ac_o, pc_load_o, pc_inc_o, data_e_o, halt_o
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  phase_t  phase_i,
  input  logic    halted_i,
  input  opcode_t opcode_i,
  input  logic    zero_i,
  output logic    sel_o,
  output logic    mem_rd_o,
  output logic    mem_wr_o,
  output logic    load_ir_o,
  output logic    load_ac_o,
  output logic    pc_load_o,
  output logic    pc_inc_o,
  output logic    data_e_o,
  output logic    halt_o
);

  logic alu_op;
  logic sto_op;

  assign alu_op = is_alu_op(opcode_i);
  assign sto_op = (opcode_i == STO);

  always_comb begin
    sel_o     = 1'b0;
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    load_ir_o = 1'b0;
    load_ac_o = 1'b0;
    pc_load_o = 1'b0;
    pc_inc_o  = 1'b0;
    data_e_o  = 1'b0;
    halt_o    = 1'b0;
    if (halted_i) begin
      halt_o = 1'b1;
    end else begin
      case (phase_i)
        INST_ADDR: sel_o = 1'b1;
        INST_FETCH: begin
          sel_o    = 1'b1;
          mem_rd_o = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel_o     = 1'b1;
          mem_rd_o  = 1'b1;
          load_ir_o = 1'b1;
        end
        OP_ADDR: begin
          // HLT flags halt in the same cycle the flag is being set, without a PC step
          if (opcode_i == HLT) halt_o   = 1'b1;
          else                 pc_inc_o = 1'b1;
        end
        OP_FETCH: mem_rd_o = alu_op;
        ALU_OP: begin
          mem_rd_o  = alu_op;
          pc_inc_o  = (opcode_i == SKZ) && zero_i;
          pc_load_o = (opcode_i == JMP);
          data_e_o  = sto_op;
        end
        STORE: begin
          mem_rd_o  = alu_op;
          load_ac_o = alu_op;
          mem_wr_o  = sto_op;
          data_e_o  = sto_op;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase instruction sequencer.
//   clk, rst - clock (rising edge), asynchronous active-high reset
//   bus      - master side of cpu_sequencer_if (opcode/zero in, strobes/phase out)
// Holds the phase counter and sticky halted flag; strobes come from cpu_seq_decode.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 3
) (
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.master bus
);

  if (OP_WIDTH != 3) begin : g_op_width_check
    $error("cpu_sequencer: OP_WIDTH must be 3");
  end

  phase_t  phase_q, phase_d;
  logic    halted_q, halted_d;
  opcode_t opcode;

  assign opcode = opcode_t'(bus.opcode);

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      // HLT parks the phase at OP_ADDR instead of advancing
      if (phase_q == OP_ADDR && opcode == HLT) halted_d = 1'b1;
      else phase_d = phase_t'(phase_q + PHASE_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  cpu_seq_decode u_decode (
    .phase_i   (phase_q),
    .halted_i  (halted_q),
    .opcode_i  (opcode),
    .zero_i    (bus.zero),
    .sel_o     (bus.sel),
    .mem_rd_o  (bus.mem_rd),
    .mem_wr_o  (bus.mem_wr),
    .load_ir_o (bus.load_ir),
    .load_ac_o (bus.load_ac),
    .pc_load_o (bus.pc_load),
    .pc_inc_o  (bus.pc_inc),
    .data_e_o  (bus.data_e),
    .halt_o    (bus.halt)
  );

  assign bus.phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench. The stimulus process drives opcode/zero/rst,
// predicts the full output word from a per-instruction phase-mask model and queues
// it; the monitor pops and compares on every falling edge.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_sequencer_if #(.OP_WIDTH(3)) bus ();

  cpu_sequencer #(.OP_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] O_HLT = 3'd0, O_SKZ = 3'd1, O_ADD = 3'd2, O_AND = 3'd3,
                         O_XOR = 3'd4, O_LDA = 3'd5, O_STO = 3'd6, O_JMP = 3'd7;

  // word = {sel, mem_rd, mem_wr, load_ir, load_ac, pc_load, pc_inc, data_e, halt, phase[2:0]}
  logic [11:0] exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // reference state
  int unsigned m_ph     = 0;
  bit          m_halted = 1'b0;

  function automatic logic [11:0] model_out(int unsigned ph, bit halted, logic [2:0] op,
                                            logic z, logic r);
    logic [7:0] sel_m, rd_m, wr_m, ir_m, ac_m, pl_m, inc_m, de_m;
    bit alu, sto, hlt_now;
    if (r) return {1'b1, 11'd0};
    if (halted) return {8'd0, 1'b1, 3'd4};
    alu     = (op == O_ADD) || (op == O_AND) || (op == O_XOR) || (op == O_LDA);
    sto     = (op == O_STO);
    hlt_now = (op == O_HLT) && (ph == 4);
    // bit n of each mask = strobe active in phase n for this instruction
    sel_m = 8'b0000_1111;
    rd_m  = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
    ir_m  = 8'b0000_1100;
    ac_m  = alu ? 8'b1000_0000 : 8'h00;
    wr_m  = sto ? 8'b1000_0000 : 8'h00;
    de_m  = sto ? 8'b1100_0000 : 8'h00;
    pl_m  = (op == O_JMP) ? 8'b0100_0000 : 8'h00;
    inc_m = ((op == O_HLT) ? 8'h00 : 8'b0001_0000) |
            ((op == O_SKZ && z) ? 8'b0100_0000 : 8'h00);
    return {sel_m[ph], rd_m[ph], wr_m[ph], ir_m[ph], ac_m[ph], pl_m[ph], inc_m[ph],
            de_m[ph], hlt_now, 3'(ph)};
  endfunction

  // one clock: drive inputs, queue expectation, advance the reference on the edge
  task automatic run_cycle(input logic [2:0] op, input logic z, input logic r);
    bus.opcode = op;
    bus.zero   = z;
    rst        = r;
    exp_q.push_back(model_out(m_ph, m_halted, op, z, r));
    @(posedge clk);
    if (r) begin
      m_ph = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_ph == 4 && op == O_HLT) m_halted = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
    #1;
  endtask

  // zmode: 0 = random zero in phase 6, 1 = force 1, 2 = force 0
  task automatic run_instr(input logic [2:0] op, input int unsigned zmode);
    for (int unsigned k = 0; k < 8; k++) begin
      logic [2:0] op_drv;
      logic       z;
      op_drv = (m_ph < 3) ? 3'($urandom) : op;
      z      = 1'($urandom);
      if (m_ph == 6 && zmode == 1) z = 1'b1;
      if (m_ph == 6 && zmode == 2) z = 1'b0;
      run_cycle(op_drv, z, 1'b0);
    end
  endtask

  initial begin : monitor
    logic [11:0] got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {bus.sel, bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac, bus.pc_load,
                bus.pc_inc, bus.data_e, bus.halt, bus.phase};
        n_vec++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL outputs vec%0d t=%0t: got %b want %b", n_vec, $time, got, want);
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0] rop;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(3'd0, 1'b0, 1'b1);
    run_cycle(3'd5, 1'b1, 1'b1);

    run_instr(O_ADD, 0);
    run_instr(O_JMP, 0);
    run_instr(O_SKZ, 1);
    run_instr(O_SKZ, 2);
    run_instr(O_STO, 0);
    run_instr(O_LDA, 0);

    for (int unsigned i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 7));
      run_instr(rop, 0);
    end

    // reset in the middle of an instruction (phase 5), async with no edge
    while (m_ph != 5) run_cycle(O_ADD, 1'($urandom), 1'b0);
    run_cycle(O_ADD, 1'b0, 1'b1);
    run_cycle(O_ADD, 1'b0, 1'b1);
    run_instr(O_XOR, 0);

    // halt and stay halted
    run_instr(O_HLT, 0);
    for (int unsigned i = 0; i < 20; i++) run_cycle(3'($urandom), 1'($urandom), 1'b0);
    run_cycle(O_HLT, 1'b0, 1'b1);
    run_instr(O_SKZ, 1);
    run_instr(O_AND, 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
